// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: rebuilds the four BCD digits shown on a multiplexed 7-segment scan,
// flagging illegal segment patterns and a stalled scan.
module seg7_scan_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        Clock,
    input  logic        Aclr,
    input  logic [6:0]  seg,
    input  logic [3:0]  dig_n,
    output logic [15:0] bcd,
    output logic [3:0]  digit_valid,
    output logic [3:0]  blank,
    output logic        frame_strobe,
    output logic        seg_err,
    output logic [7:0]  err_count,
    output logic        stale
);
    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    logic [6:0]  seg_m_q, seg_s_q, pat_q, pat_d;
    logic [3:0]  dig_m_q, dig_s_q;
    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d, k_s;
    logic [7:0]  cnt_q, cnt_d, err_count_q, err_count_d;
    logic [15:0] to_q, to_d, bcd_q, bcd_d;
    logic [3:0]  valid_q, valid_d, blank_q, blank_d, mask_q, mask_d, mask_m, bit_k, dec_val;
    logic        strobe_q, strobe_d, seg_err_q, seg_err_d, stale_q, stale_d;
    logic        sel_ok, same, cap, ok, expire, dec_ok, dec_blank;

    always_comb begin
        dec_val   = 4'hF;
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        case (pat_q)
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b0011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1110011: dec_val = 4'd9;
            7'b0000000: dec_blank = 1'b1;
            default:    dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        sel_ok  = $onehot(~dig_s_q);
        k_s     = !dig_s_q[0] ? 2'd0 : !dig_s_q[1] ? 2'd1 : !dig_s_q[2] ? 2'd2 : 2'd3;
        same    = sel_ok && k_s == k_q && seg_s_q == pat_q;
        cap     = state_q == TRACK && cnt_q == 8'(STABLE_CYCLES);
        state_d = state_q;
        k_d     = k_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        // Capture uses the latched sample; HOLD re-arms only on a change.
        if (cap)
            state_d = HOLD;
        else if (state_q == TRACK && same)
            cnt_d = cnt_q + 8'd1;
        else if (!(state_q == HOLD && same)) begin
            state_d = sel_ok ? TRACK : IDLE;
            k_d     = k_s;
            pat_d   = seg_s_q;
            cnt_d   = 8'd1;
        end
        ok          = cap && dec_ok;
        bit_k       = 4'b0001 << k_q;
        bcd_d       = bcd_q;
        if (ok)
            bcd_d[{k_q, 2'b00} +: 4] = dec_val;
        to_d        = ok ? 16'd0 : to_q == 16'(TIMEOUT_CYCLES) ? to_q : to_q + 16'd1;
        expire      = !ok && to_d == 16'(TIMEOUT_CYCLES);
        mask_m      = mask_q | (ok ? bit_k : 4'b0000);
        strobe_d    = mask_m == 4'hF;
        mask_d      = (expire || strobe_d) ? 4'b0000 : mask_m;
        valid_d     = expire ? 4'b0000 : valid_q | (ok ? bit_k : 4'b0000);
        blank_d     = expire ? 4'b0000 : ok ? (blank_q & ~bit_k) | (dec_blank ? bit_k : 4'b0000) : blank_q;
        stale_d     = ok ? 1'b0 : expire ? 1'b1 : stale_q;
        seg_err_d   = cap && !dec_ok;
        err_count_d = err_count_q + {7'd0, seg_err_d && err_count_q != 8'hFF};
    end

    always_ff @(posedge Clock or negedge Aclr) begin
        if (!Aclr) begin
            seg_m_q     <= '0;
            seg_s_q     <= '0;
            dig_m_q     <= '0;
            dig_s_q     <= '0;
            state_q     <= IDLE;
            k_q         <= '0;
            pat_q       <= '0;
            cnt_q       <= '0;
            to_q        <= '0;
            bcd_q       <= '0;
            valid_q     <= '0;
            blank_q     <= '0;
            mask_q      <= '0;
            strobe_q    <= 1'b0;
            seg_err_q   <= 1'b0;
            err_count_q <= '0;
            stale_q     <= 1'b0;
        end else begin
            seg_m_q     <= seg;
            seg_s_q     <= seg_m_q;
            dig_m_q     <= dig_n;
            dig_s_q     <= dig_m_q;
            state_q     <= state_d;
            k_q         <= k_d;
            pat_q       <= pat_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            bcd_q       <= bcd_d;
            valid_q     <= valid_d;
            blank_q     <= blank_d;
            mask_q      <= mask_d;
            strobe_q    <= strobe_d;
            seg_err_q   <= seg_err_d;
            err_count_q <= err_count_d;
            stale_q     <= stale_d;
        end
    end

    assign bcd          = bcd_q;
    assign digit_valid  = valid_q;
    assign blank        = blank_q;
    assign frame_strobe = strobe_q;
    assign seg_err      = seg_err_q;
    assign err_count    = err_count_q;
    assign stale        = stale_q;
endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive end of the multiplexed 7-segment display interface driven by the counter plus 74HC4511-style decoder path.
- Samples the segment lines a..g and the digit-select lines Y1..Y4, and reconstructs the four displayed BCD digits.
- Flags illegal segment patterns and a stalled scan.
- Used for board self-check and loopback of the display drive.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a digit is captured (range 2..255).
- TIMEOUT_CYCLES, 1024: clocks without any capture before the stale flag asserts (range 16..65535).

Ports:
- Clock  in  1  system clock, rising edge.
- Aclr  in  1  asynchronous active-low reset.
- seg  in  7  segment lines, active-high; seg[6]=a ... seg[0]=g.
- dig_n  in  4  digit selects, active-low; dig_n[0]=Y1 ... dig_n[3]=Y4.
- bcd  out  16  captured digits; bcd[4k+3:4k] is digit k.
- digit_valid  out  4  bit k set once digit k has been captured since reset or stale.
- blank  out  4  bit k set when digit k was last captured as all-segments-off.
- frame_strobe  out  1  one-clock pulse when all four digits have been captured since the previous strobe.
- seg_err  out  1  one-clock pulse on a stable but illegal segment pattern.
- err_count  out  8  saturating count of seg_err pulses.
- stale  out  1  no capture for TIMEOUT_CYCLES clocks.

Behaviour:
- Reset (Aclr=0, async): all outputs 0; bcd=16'h0000; synchronizers, counters and FSM cleared; FSM enters IDLE.
- Input path: seg and dig_n each pass through a 2-flop synchronizer. All logic below uses the synchronized values.
- Legal select: exactly one bit of dig_n low. Digit index k = position of that low bit.
- FSM IDLE: wait for a legal select, then load the stability counter with 1, latch (k, seg) and go to TRACK.
- FSM TRACK:
  - Each clock with the same (k, seg): counter increments.
  - Any change, or an illegal select: go to IDLE. If the new select is legal, reload from it in the same clock.
  - Counter reaches STABLE_CYCLES: do the capture below, then go to HOLD.
- Capture is a single clock:
  - Legal pattern: bcd[k] is written, digit_valid[k]=1, blank[k] is updated, frame mask bit k is set, and the timeout counter is cleared.
  - Illegal pattern: seg_err pulses, err_count increments (saturates at 255), and bcd, digit_valid and the mask are unchanged.
- FSM HOLD: stay while (k, seg) is unchanged. On any change behave as IDLE on that same clock. No re-capture while held.
- Legal patterns (a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=0011111, 7=1110000, 8=1111111, 9=1110011
  - Blank 0000000 stores 4'hF and sets blank[k]. Any other pattern is illegal.
- Latency: an input held stable from edge N gives an updated bcd/digit_valid visible after edge N+2+STABLE_CYCLES.
- Frame:
  - When the mask reaches 4'b1111, frame_strobe=1 for one clock and the mask clears on that same clock.
  - A capture landing on the strobe clock sets its bit in the cleared mask.
  - Recapturing the same digit before the frame completes overwrites bcd and does not produce a strobe.
- Timeout:
  - The counter increments every clock and saturates. When it reaches TIMEOUT_CYCLES: stale=1, digit_valid=0, blank=0, mask cleared. bcd retains its last value.
  - The next legal capture clears stale.
- Simultaneous events: a capture and timeout expiry on the same clock resolve as capture (stale stays 0). seg_err and frame_strobe are never both asserted on one clock.
- Reset mid-capture: reset dominates immediately. No pulse outputs appear during or after Aclr low.

Test Plan:
- Scan "1234": dig_n 1110/seg 0110000, 1101/1101101, 1011/1111001, 0111/0110011, each held 8 clocks -> bcd=16'h4321, digit_valid=4'hF, one frame_strobe at the 4th capture, seg_err never asserted.
- Stability: seg=1111111 on Y1 held 3 clocks then glitched, with STABLE_CYCLES=4 -> no capture. Held 4 clocks -> bcd[3:0]=8 after 2+4 clocks.
- Illegal pattern 1000001 on Y2 held 10 clocks -> exactly one seg_err pulse, err_count=1, bcd[7:4] unchanged. Repeated 300 times with intervening changes -> err_count=255.
- Blank and bad selects: dig_n=1011 with seg=0 -> bcd[11:8]=4'hF, blank[2]=1. dig_n=1100 or 1111 for 20 clocks -> no capture, FSM in IDLE.
- Timeout: after a frame, hold dig_n=1111 for 1024 clocks -> stale=1, digit_valid=0, bcd retained. Then a legal Y4 capture -> stale=0, digit_valid=4'b1000.
- Async reset: assert Aclr=0 mid-TRACK, off the clock edge -> all outputs 0 immediately. After release, the 4-digit scan works as in the first scenario.
